cnn_layer_sequencer: RTL and testbench
======================================

# cnn_layer_sequencer

Sequencer for the three-layer convolution datapath. It streams the image and the layer-1/2/3 kernel weights from a host valid/ready stream onto the datapath's shared data/addr/we load bus, and drives the matching mode strobes (img_input, conv_weight1..3). It then starts each layer in turn with srt_layerN and waits for done_layerN, with a per-layer timeout. It sits between the host/DMA stream and the convolution top.

## Interface
- IMG_SIZE, 18, input image side length; image word count is IMG_SIZE².
- N_K1 / N_K2 / N_K3, 6 / 16 / 32, kernel counts for layers 1/2/3.
- KSZ, 9, words per kernel (3×3).
- TIMEOUT, 65535, maximum cycles allowed in one run state.
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  begin a run; sampled in IDLE or ERR only.
- reuse_w  in  1  sampled with start; 1 skips all weight loads.
- abort  in  1  return to IDLE immediately; highest priority.
- s_valid / s_ready  in / out  1  host stream handshake.
- s_data  in  16  host word: image first, then W1, W2, W3, each kernel-major.
- data / addr  out  16  load bus to the datapath.
- we  out  1  load-bus write enable.
- img_input, conv_weight1, conv_weight2, conv_weight3  out  1  load-mode strobes.
- srt_layer1..3  out  1  layer run strobes.
- done_layer1..3  in  1  layer completion from the datapath.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse when a run completes.
- err  out  1  timeout flag; sticky.
- state_o  out  4  current state code.

## Operation
- **States:** IDLE, L_IMG, L_W1, L_W2, L_W3, GAP, R_L1, R_L2, R_L3, FIN, ERR.
- **Run order:**
  - reuse_w=0: IDLE → L_IMG → L_W1 → L_W2 → L_W3 → R_L1 → R_L2 → R_L3 → FIN → IDLE.
  - reuse_w=1: IDLE → L_IMG → R_L1 → R_L2 → R_L3 → FIN → IDLE.
  - Every load or run state exits through exactly one GAP cycle, in which all strobes, we and s_ready are 0.
- **Load state, phase by phase:**
  - Setup cycle: own strobe=1, s_ready=0.
  - Accept phase: s_ready=1 until the last word is accepted.
  - Each accept (s_valid & s_ready) registers data=s_data, addr and we=1 for exactly the next cycle. Otherwise we=0 and data/addr hold their values.
  - Tail: one cycle after the last write, with strobe=1, we=0, s_ready=0. Then GAP.
- **Word counts:** image IMG_SIZE² (324); W1 N_K1·KSZ (54); W2 N_K2·KSZ (144); W3 N_K3·KSZ (288).
- **addr:**
  - Image: word index 0..IMG_SIZE²−1.
  - Weights: index mod KSZ (0..8), restarting at 0 for each kernel.
- **Run state R_LN:**
  - srt_layerN=1 from entry until done_layerN is sampled 1.
  - The cycle in which done_layerN is sampled high is the last cycle with srt_layerN=1; the next cycle is GAP.
  - done_layerM for M≠N, and any done_layer outside run states, is ignored.
- **Timeout:** a counter clears on entry to each R_LN. If it reaches TIMEOUT with done_layerN still low, the next state is ERR with err=1, all strobes and busy low.
- **ERR:** held until start (clears err, begins a new run) or abort (clears err, goes to IDLE).
- **Flags:** busy=1 in every state except IDLE and ERR. done=1 only in FIN (a single cycle).
- **Ignored / priority inputs:**
  - start while busy is ignored; reuse_w is latched only when start is accepted.
  - abort in any state returns to IDLE on the next edge: all outputs 0, counters cleared, no done pulse, err cleared.
  - abort and start in the same cycle: abort wins.
- **Reset:** every output 0, state IDLE, all counters 0. Applies equally to reset asserted mid-run.

## Timing
- All outputs are registered.
- start accepted at edge t → state L_IMG from t+1. Its setup cycle is t+1, so s_ready rises at t+2.
- With s_valid held high, each load state lasts words+2 cycles (324 → 326), plus 1 GAP.
- Write latency: accept at cycle c → we/data/addr valid in cycle c+1.
- s_valid bubbles stretch the accept phase only; no word is lost or duplicated.
- done pulses 1 cycle after the R_L3 GAP cycle; IDLE follows on the next cycle.

## Structure
- Package cnn_seq_pkg:
  - state enum and 4-bit codes;
  - word-count localparams derived from IMG_SIZE, N_K*, KSZ;
  - TIMEOUT width function.
- Sub-module cnn_load_addr_gen: word counter plus kernel-relative addr (mod KSZ), with a last-word flag. One instance is shared by all load states and cleared on each entry.

## Test plan
- **Full run, reuse_w=0, continuous s_valid:**
  - 324+54+144+288 = 810 writes.
  - Weight addr pattern 0..8 repeating.
  - Each srt_layerN drops the cycle after done_layerN; exactly one done pulse.
- **reuse_w=1:** conv_weight1..3 never asserted; 324 writes; R_L1 entered 327 cycles after start.
- **Random s_valid bubbles (50%):** written data sequence equals the input sequence; no write while s_valid was low.
- **TIMEOUT=20, done_layer2 never asserted:** ERR 20 cycles after R_L2 entry; err=1, srt_layer2=0; a following start clears err.
- **abort at W2 word 70:** next cycle all outputs 0, state IDLE, no done. Same for reset_n low mid R_L1.
- **start pulsed during L_W1 and done_layer3 pulsed during R_L1:** no effect on sequence or counts.

Source files
------------

// File: rtl/cnn_seq_pkg.sv
// Shared types and helpers for the CNN layer sequencer: state codes, load
// sub-phases, default dimensions and small derivation functions.
package cnn_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_L_IMG = 4'd1,
    S_L_W1  = 4'd2,
    S_L_W2  = 4'd3,
    S_L_W3  = 4'd4,
    S_GAP   = 4'd5,
    S_R_L1  = 4'd6,
    S_R_L2  = 4'd7,
    S_R_L3  = 4'd8,
    S_FIN   = 4'd9,
    S_ERR   = 4'd10
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_ACCEPT,
    PH_TAIL
  } phase_e;

  localparam int IMG_SIZE_DEF = 18;
  localparam int N_K1_DEF     = 6;
  localparam int N_K2_DEF     = 16;
  localparam int N_K3_DEF     = 32;
  localparam int KSZ_DEF      = 9;
  localparam int TIMEOUT_DEF  = 65535;

  function automatic int img_words(input int side);
    return side * side;
  endfunction

  function automatic int w_words(input int n_k, input int ksz);
    return n_k * ksz;
  endfunction

  // Wide enough to hold the value TIMEOUT itself.
  function automatic int tmo_width(input int tmo);
    return (tmo < 1) ? 1 : $clog2(tmo + 1);
  endfunction

  function automatic logic is_load(input state_e s);
    return (s == S_L_IMG) || (s == S_L_W1) || (s == S_L_W2) || (s == S_L_W3);
  endfunction

  // State entered after the GAP that follows s.
  function automatic state_e next_state(input state_e s, input logic reuse);
    case (s)
      S_L_IMG: return reuse ? S_R_L1 : S_L_W1;
      S_L_W1:  return S_L_W2;
      S_L_W2:  return S_L_W3;
      S_L_W3:  return S_R_L1;
      S_R_L1:  return S_R_L2;
      S_R_L2:  return S_R_L3;
      S_R_L3:  return S_FIN;
      default: return S_IDLE;
    endcase
  endfunction

  // {conv_weight3, conv_weight2, conv_weight1, img_input}
  function automatic logic [3:0] load_strobe(input state_e s);
    case (s)
      S_L_IMG: return 4'b0001;
      S_L_W1:  return 4'b0010;
      S_L_W2:  return 4'b0100;
      S_L_W3:  return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  // {srt_layer3, srt_layer2, srt_layer1}
  function automatic logic [2:0] run_strobe(input state_e s);
    case (s)
      S_R_L1:  return 3'b001;
      S_R_L2:  return 3'b010;
      S_R_L3:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/cnn_load_addr_gen.sv
// Load-bus word counter: absolute word index, kernel-relative address
// (index mod KSZ) and a flag marking the final word of the current segment.
module cnn_load_addr_gen #(
  parameter int KSZ = 9
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        inc_i,
  input  logic [15:0] words_i,
  output logic [15:0] idx_o,
  output logic [15:0] kaddr_o,
  output logic        last_o
);

  logic [15:0] idx_q;
  logic [15:0] kaddr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q   <= '0;
      kaddr_q <= '0;
    end else if (clr_i) begin
      idx_q   <= '0;
      kaddr_q <= '0;
    end else if (inc_i) begin
      idx_q   <= idx_q + 16'd1;
      kaddr_q <= (kaddr_q == 16'(KSZ - 1)) ? 16'd0 : kaddr_q + 16'd1;
    end
  end

  assign idx_o   = idx_q;
  assign kaddr_o = kaddr_q;
  assign last_o  = (idx_q == words_i - 16'd1);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Streams image and kernel weights onto the convolution load bus, then runs
// layers 1..3 in order with a per-layer timeout. All outputs are registered.
module cnn_layer_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int IMG_SIZE = IMG_SIZE_DEF,
  parameter int N_K1     = N_K1_DEF,
  parameter int N_K2     = N_K2_DEF,
  parameter int N_K3     = N_K3_DEF,
  parameter int KSZ      = KSZ_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        reuse_w,
  input  logic        abort,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic [15:0] data,
  output logic [15:0] addr,
  output logic        we,
  output logic        img_input,
  output logic        conv_weight1,
  output logic        conv_weight2,
  output logic        conv_weight3,
  output logic        srt_layer1,
  output logic        srt_layer2,
  output logic        srt_layer3,
  input  logic        done_layer1,
  input  logic        done_layer2,
  input  logic        done_layer3,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [3:0]  state_o
);

  localparam int          TW        = tmo_width(TIMEOUT);
  localparam logic [15:0] IMG_WORDS = 16'(img_words(IMG_SIZE));
  localparam logic [15:0] W1_WORDS  = 16'(w_words(N_K1, KSZ));
  localparam logic [15:0] W2_WORDS  = 16'(w_words(N_K2, KSZ));
  localparam logic [15:0] W3_WORDS  = 16'(w_words(N_K3, KSZ));

  state_e        state_q, ret_q;
  phase_e        phase_q;
  logic          reuse_q;
  logic [TW-1:0] tcnt_q;
  logic          s_ready_q, we_q, busy_q, done_q, err_q;
  logic [15:0]   data_q, addr_q;
  logic [3:0]    ld_strb_q;
  logic [2:0]    srt_q;

  logic [15:0]   words, idx, kaddr;
  logic          last, accept, gen_clr, done_sel;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    words    = '0;
    done_sel = 1'b0;
    case (state_q)
      S_L_IMG: words = IMG_WORDS;
      S_L_W1:  words = W1_WORDS;
      S_L_W2:  words = W2_WORDS;
      S_L_W3:  words = W3_WORDS;
      S_R_L1:  done_sel = done_layer1;
      S_R_L2:  done_sel = done_layer2;
      S_R_L3:  done_sel = done_layer3;
      default: ;
    endcase
  end

  assign accept  = s_valid & s_ready_q;
  // Counter restarts during each setup cycle, so every load segment begins at word 0.
  assign gen_clr = abort | ~is_load(state_q) | (phase_q == PH_SETUP);

  cnn_load_addr_gen #(.KSZ(KSZ)) u_addr_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (gen_clr),
    .inc_i   (accept),
    .words_i (words),
    .idx_o   (idx),
    .kaddr_o (kaddr),
    .last_o  (last)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;  ret_q  <= S_IDLE;  phase_q <= PH_SETUP;
      reuse_q <= 1'b0;    tcnt_q <= '0;
      s_ready_q <= 1'b0;  we_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
      data_q <= '0;  addr_q <= '0;  ld_strb_q <= '0;  srt_q <= '0;
    end else if (abort) begin
      state_q <= S_IDLE;  ret_q  <= S_IDLE;  phase_q <= PH_SETUP;
      reuse_q <= 1'b0;    tcnt_q <= '0;
      s_ready_q <= 1'b0;  we_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
      data_q <= '0;  addr_q <= '0;  ld_strb_q <= '0;  srt_q <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_q   <= S_L_IMG;
            reuse_q   <= reuse_w;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            phase_q   <= PH_SETUP;
            ld_strb_q <= load_strobe(S_L_IMG);
          end
        end
        S_L_IMG, S_L_W1, S_L_W2, S_L_W3: begin
          case (phase_q)
            PH_SETUP: begin
              s_ready_q <= 1'b1;
              phase_q   <= PH_ACCEPT;
            end
            PH_ACCEPT: begin
              if (accept) begin
                we_q   <= 1'b1;
                data_q <= s_data;
                addr_q <= (state_q == S_L_IMG) ? idx : kaddr;
                if (last) begin
                  s_ready_q <= 1'b0;
                  phase_q   <= PH_TAIL;
                end
              end
            end
            default: begin
              state_q   <= S_GAP;
              ret_q     <= next_state(state_q, reuse_q);
              ld_strb_q <= '0;
            end
          endcase
        end
        S_R_L1, S_R_L2, S_R_L3: begin
          if (done_sel) begin
            state_q <= S_GAP;
            ret_q   <= next_state(state_q, reuse_q);
            srt_q   <= '0;
          end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_q <= S_ERR;
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            srt_q   <= '0;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_GAP: begin
          state_q   <= ret_q;
          phase_q   <= PH_SETUP;
          tcnt_q    <= '0;
          ld_strb_q <= load_strobe(ret_q);
          srt_q     <= run_strobe(ret_q);
          done_q    <= (ret_q == S_FIN);
        end
        S_FIN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign data         = data_q;
  assign addr         = addr_q;
  assign we           = we_q;
  assign img_input    = ld_strb_q[0];
  assign conv_weight1 = ld_strb_q[1];
  assign conv_weight2 = ld_strb_q[2];
  assign conv_weight3 = ld_strb_q[3];
  assign srt_layer1   = srt_q[0];
  assign srt_layer2   = srt_q[1];
  assign srt_layer3   = srt_q[2];
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Directed bench for cnn_layer_sequencer: a host stream model, a load-bus
// monitor and a linear sequence of runs checked against hand-computed values.
module tb_cnn_layer_sequencer;
  import cnn_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, reuse_w = 1'b0, abort = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;
  logic [2:0]  dl = '0;

  logic        s_ready, we, img_input, conv_weight1, conv_weight2, conv_weight3;
  logic        srt_layer1, srt_layer2, srt_layer3, busy, done, err;
  logic [15:0] data, addr;
  logic [3:0]  state_o;
  logic [2:0]  srt_vec;
  logic [47:0] outs;

  int n_vec = 0, n_fail = 0;
  int seq = 0, bubble = 0;
  int wr_total = 0, wr_img = 0, wr_w = 0, wr_w2 = 0;
  int data_bad = 0, addr_bad = 0, we_bad = 0, cw_cycles = 0, done_cnt = 0;
  logic acc_prev = 1'b0;

  assign srt_vec = {srt_layer3, srt_layer2, srt_layer1};
  assign outs = {data, addr, we, img_input, conv_weight1, conv_weight2, conv_weight3,
                 srt_vec, busy, done, err, s_ready, state_o};

  cnn_layer_sequencer #(.TIMEOUT(20)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .reuse_w(reuse_w), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .data(data), .addr(addr), .we(we),
    .img_input(img_input), .conv_weight1(conv_weight1),
    .conv_weight2(conv_weight2), .conv_weight3(conv_weight3),
    .srt_layer1(srt_layer1), .srt_layer2(srt_layer2), .srt_layer3(srt_layer3),
    .done_layer1(dl[0]), .done_layer2(dl[1]), .done_layer3(dl[2]),
    .busy(busy), .done(done), .err(err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] word_of(input int i);
    return 16'(i * 37 + 11);
  endfunction

  // Host stream: the word offered is always the next one not yet accepted.
  initial begin
    forever begin
      @(posedge clk);
      if (s_valid && s_ready && !abort && reset_n) seq++;
      #1;
      if (reset_n && ($urandom_range(99) >= 32'(bubble))) begin
        s_valid = 1'b1;
        s_data  = word_of(seq);
      end else begin
        s_valid = 1'b0;
      end
    end
  end

  // Load-bus monitor: each write must follow exactly one accept, in order.
  always @(negedge clk) begin
    if (we !== acc_prev) we_bad++;
    if (we === 1'b1) begin
      if (data !== word_of(wr_total)) data_bad++;
      if (img_input) begin
        if (addr !== 16'(wr_img)) addr_bad++;
        wr_img++;
      end else begin
        if (addr !== 16'(wr_w % 9)) addr_bad++;
        wr_w++;
        if (conv_weight2) wr_w2++;
      end
      wr_total++;
    end
    if (conv_weight1 | conv_weight2 | conv_weight3) cw_cycles++;
    if (done) done_cnt++;
    acc_prev = s_valid & s_ready & ~abort & reset_n;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input state_e code, input int budget, output int n, input string tag);
    n = 0;
    while (state_o !== code && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, state_o, code);
  endtask

  task automatic start_run(input logic r);
    @(posedge clk); #2;
    seq = 0; wr_total = 0; wr_img = 0; wr_w = 0; wr_w2 = 0;
    data_bad = 0; addr_bad = 0; we_bad = 0; cw_cycles = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; reuse_w = r;
    @(posedge clk); #1;
    start = 1'b0; reuse_w = 1'b0;
  endtask

  task automatic serve_layer(input state_e st, input int idx, input int lat);
    int n;
    logic [2:0] want;
    want = 3'b001 << idx;
    wait_state(st, 3000, n, "enter_run_state");
    check("srt_on_entry", srt_vec, want);
    repeat (lat) begin @(posedge clk); #1; end
    dl[idx] = 1'b1;
    @(negedge clk);
    check("srt_held_with_done", srt_vec, want);
    @(posedge clk); #1;
    dl[idx] = 1'b0;
    check("srt_drop_to_gap", {state_o, srt_vec}, {S_GAP, 3'b000});
    check("gap_quiet", {we, s_ready, img_input, conv_weight1, conv_weight2, conv_weight3}, 6'd0);
  endtask

  task automatic finish_run();
    @(posedge clk); #1;
    check("fin_done_pulse", {state_o, done, busy}, {S_FIN, 1'b1, 1'b1});
    @(posedge clk); #1;
    check("idle_after_fin", {state_o, done, busy}, {S_IDLE, 1'b0, 1'b0});
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs, 48'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("idle_outs", outs, 48'd0);

    // Full run, continuous stream, with a stray start and a stray done_layer3.
    start_run(1'b0);
    check("l_img_setup", {state_o, img_input, s_ready, busy}, {S_L_IMG, 3'b101});
    @(posedge clk); #1;
    check("s_ready_rises", s_ready, 1'b1);
    wait_state(S_L_W1, 1000, n, "enter_l_w1");
    start = 1'b1; reuse_w = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; reuse_w = 1'b0;
    check("start_while_busy", state_o, S_L_W1);
    wait_state(S_R_L1, 1500, n, "enter_r_l1");
    dl[2] = 1'b1;
    @(posedge clk); #1;
    dl[2] = 1'b0;
    check("stray_done3", {state_o, srt_vec}, {S_R_L1, 3'b001});
    serve_layer(S_R_L1, 0, 3);
    serve_layer(S_R_L2, 1, 5);
    serve_layer(S_R_L3, 2, 0);
    finish_run();
    check("full_writes", wr_total, 810);
    check("full_img_writes", wr_img, 324);
    check("full_w_writes", wr_w, 486);
    check("full_w_cycles", cw_cycles, 492);
    check("full_data", data_bad, 0);
    check("full_addr", addr_bad, 0);
    check("full_we", we_bad, 0);
    check("full_done_cnt", done_cnt, 1);

    // Weight reuse: image only.
    start_run(1'b1);
    wait_state(S_R_L1, 1000, n, "reuse_enter_r_l1");
    check("reuse_latency", n, 327);
    serve_layer(S_R_L1, 0, 2);
    serve_layer(S_R_L2, 1, 2);
    serve_layer(S_R_L3, 2, 2);
    finish_run();
    check("reuse_writes", wr_total, 324);
    check("reuse_no_weights", cw_cycles, 0);
    check("reuse_data", data_bad, 0);
    check("reuse_done_cnt", done_cnt, 1);

    // Random stream bubbles.
    bubble = 50;
    start_run(1'b0);
    serve_layer(S_R_L1, 0, 1);
    serve_layer(S_R_L2, 1, 1);
    serve_layer(S_R_L3, 2, 1);
    finish_run();
    bubble = 0;
    check("bubble_writes", wr_total, 810);
    check("bubble_data", data_bad, 0);
    check("bubble_addr", addr_bad, 0);
    check("bubble_we", we_bad, 0);

    // Timeout in layer 2.
    start_run(1'b1);
    serve_layer(S_R_L1, 0, 2);
    wait_state(S_R_L2, 100, n, "enter_r_l2");
    wait_state(S_ERR, 100, n, "timeout_err");
    check("timeout_cycles", n, 20);
    check("err_flags", {err, busy, srt_vec, s_ready}, {1'b1, 1'b0, 3'b000, 1'b0});
    repeat (3) begin @(posedge clk); #1; end
    check("err_held", {state_o, err}, {S_ERR, 1'b1});
    check("err_no_done", done_cnt, 0);

    // Restart from ERR, then abort part-way through W2.
    start_run(1'b0);
    check("restart_clears_err", {state_o, err, busy}, {S_L_IMG, 1'b0, 1'b1});
    n = 0;
    while (wr_w2 < 70 && n < 2000) begin @(negedge clk); n++; end
    check("reach_w2_word70", wr_w2 >= 70, 1'b1);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_outs", outs, 48'd0);
    repeat (4) begin @(posedge clk); #1; end
    check("abort_stays_idle", outs, 48'd0);
    check("abort_no_done", done_cnt, 0);

    // Asynchronous reset in the middle of R_L1.
    start_run(1'b1);
    wait_state(S_R_L1, 1000, n, "reset_enter_r_l1");
    #3;
    reset_n = 1'b0;
    #1;
    check("midrun_reset_outs", outs, 48'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("after_reset_idle", outs, 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
